// File: rtl/alarm_timer_pkg.sv
// Shared types and constants for the alarm timer: FSM states, count type and
// the default counter modulus.
package alarm_timer_pkg;

   typedef logic [31:0] count_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   localparam int unsigned CNT_MAX_DEFAULT = 32'h7fff_ffff;
   localparam logic [32:0] CNT_MOD = {1'b0, CNT_MAX_DEFAULT} + 33'd1;

   // A zero delta stands for one full period of the upstream counter.
   function automatic count_t delta_eff(input logic [30:0] delta, input logic [32:0] modulus);
      return (delta == 31'd0) ? modulus[31:0] : {1'b0, delta};
   endfunction

endpackage

// File: rtl/alarm_timer_mod_add_wrap.sv
// Combinational (a + b) mod (CNT_MAX+1) with a 33-bit intermediate.
// Operands are bounded (a <= CNT_MAX, b <= CNT_MAX+1), so one subtraction suffices.
module mod_add_wrap
   import alarm_timer_pkg::*;
#(
   parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
   input  count_t a,
   input  count_t b,
   output count_t sum
);

   localparam logic [32:0] MOD = {1'b0, CNT_MAX} + 33'd1;

   logic [32:0] raw;

   assign raw = {1'b0, a} + {1'b0, b};

   always_comb begin
      sum = raw[31:0];
      if (raw >= MOD) begin
         sum = 32'(raw - MOD);
      end
   end

endmodule

// File: rtl/alarm_timer.sv
// Alarm timer: fires when the upstream free-running count reaches a programmed
// target, one-shot or periodic, with a valid/ready alarm output and sticky overrun.
module alarm_timer
   import alarm_timer_pkg::*;
#(
   parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  count_t      count_in,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [30:0] cfg_delta,
   input  logic        cfg_periodic,
   input  logic        cancel,
   output logic        alarm_valid,
   input  logic        alarm_ready,
   output count_t      alarm_stamp,
   output logic        overrun,
   output logic        busy,
   output state_t      state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; valid holds its payload until that edge, ready never waits on valid.

   localparam logic [32:0] MOD = {1'b0, CNT_MAX} + 33'd1;

   state_t state, state_nx;
   count_t target, delta_q, cfg_delta_eff, sum_init, sum_rearm;
   logic   periodic_q, accept, fire;

   assign cfg_delta_eff = delta_eff(cfg_delta, MOD);
   assign accept        = cfg_valid && cfg_ready;
   assign fire          = (state == ARMED) && (count_in == target) && !cancel;
   assign cfg_ready     = (state == IDLE) && !reset;
   assign busy          = (state != IDLE);
   assign state_dbg     = state;

   mod_add_wrap #(.CNT_MAX(CNT_MAX)) u_add_init (
      .a   (count_in),
      .b   (cfg_delta_eff),
      .sum (sum_init)
   );

   mod_add_wrap #(.CNT_MAX(CNT_MAX)) u_add_rearm (
      .a   (target),
      .b   (delta_q),
      .sum (sum_rearm)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) state_nx = ARMED;
         end
         ARMED: begin
            if (cancel) state_nx = IDLE;
            else if (fire && !periodic_q) state_nx = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (alarm_valid && alarm_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         target      <= '0;
         delta_q     <= '0;
         periodic_q  <= 1'b0;
         alarm_valid <= 1'b0;
         alarm_stamp <= '0;
         overrun     <= 1'b0;
      end else begin
         if (accept) begin
            target     <= sum_init;
            delta_q    <= cfg_delta_eff;
            periodic_q <= cfg_periodic;
            overrun    <= 1'b0;
         end else if (fire && periodic_q) begin
            target <= sum_rearm;
         end
         // A fire while the previous event is still unaccepted is dropped.
         if (fire) begin
            if (!alarm_valid || alarm_ready) begin
               alarm_valid <= 1'b1;
               alarm_stamp <= target;
            end else begin
               overrun <= 1'b1;
            end
         end else if (alarm_valid && alarm_ready) begin
            alarm_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer: full-width instance plus a CNT_MAX=15
// instance for the full-period case.
module tb_alarm_timer;
   import alarm_timer_pkg::*;

   localparam int unsigned CNT_MAX = 32'h7fff_ffff;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [31:0] count_in = 32'd0;
   logic [31:0] count2 = 32'd0;
   logic        cfg_valid = 1'b0, cfg_valid2 = 1'b0;
   logic [30:0] cfg_delta = '0;
   logic        cfg_periodic = 1'b0, cancel = 1'b0, alarm_ready = 1'b1;
   logic        cfg_ready, alarm_valid, overrun, busy;
   logic [31:0] alarm_stamp;
   state_t      state_dbg;
   logic        cfg_ready2, alarm_valid2, overrun2, busy2;
   logic [31:0] alarm_stamp2;
   state_t      state_dbg2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];

   alarm_timer dut (
      .clock(clock), .reset(reset), .count_in(count_in), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_delta(cfg_delta), .cfg_periodic(cfg_periodic),
      .cancel(cancel), .alarm_valid(alarm_valid), .alarm_ready(alarm_ready),
      .alarm_stamp(alarm_stamp), .overrun(overrun), .busy(busy), .state_dbg(state_dbg)
   );

   alarm_timer #(.CNT_MAX(15)) dut16 (
      .clock(clock), .reset(reset), .count_in(count2), .cfg_valid(cfg_valid2),
      .cfg_ready(cfg_ready2), .cfg_delta(cfg_delta), .cfg_periodic(cfg_periodic),
      .cancel(cancel), .alarm_valid(alarm_valid2), .alarm_ready(alarm_ready),
      .alarm_stamp(alarm_stamp2), .overrun(overrun2), .busy(busy2), .state_dbg(state_dbg2)
   );

   // driver: advance one clock, then update the registered upstream counts
   task automatic step();
      @(posedge clock);
      #1;
      count_in = (count_in == CNT_MAX) ? 32'd0 : count_in + 32'd1;
      count2   = (count2 == 32'd15) ? 32'd0 : count2 + 32'd1;
      cyc++;
   endtask

   task automatic wait_valid(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (alarm_valid) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cfg_valid = 1'b1; cfg_delta = 31'd5;
      step(); step();
      checks++; if (alarm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", alarm_valid); end
      checks++; if (alarm_stamp !== 32'd0) begin errors++; $display("FAIL reset_stamp: got %0d want 0", alarm_stamp); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b want 0", cfg_ready); end
      reset = 1'b0; cfg_valid = 1'b0;
      #1;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL release_cfg_ready: got %b want 1", cfg_ready); end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_cancel_busy: got %b want 0", busy); end
   endtask

   task automatic test_oneshot();
      bit seen;
      logic [31:0] e;
      count_in = 32'd100; cfg_valid = 1'b1; cfg_delta = 31'd5; cfg_periodic = 1'b0; alarm_ready = 1'b1;
      exp_q.push_back(32'd105);
      step();
      cfg_valid = 1'b0;
      checks++; if (state_dbg !== ARMED) begin errors++; $display("FAIL oneshot_armed: got %0d want %0d", state_dbg, ARMED); end
      wait_valid(20, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL oneshot_timeout: got no alarm want alarm"); end
      else begin
         e = exp_q.pop_front();
         if (count_in !== 32'd106 || alarm_stamp !== e) begin
            errors++; $display("FAIL oneshot_event: got count=%0d stamp=%0d want count=106 stamp=%0d", count_in, alarm_stamp, e);
         end
      end
      step();
      checks++; if (alarm_valid !== 1'b0 || cfg_ready !== 1'b1 || state_dbg !== IDLE) begin
         errors++; $display("FAIL oneshot_idle: got valid=%b ready=%b state=%0d want 0 1 0", alarm_valid, cfg_ready, state_dbg);
      end
   endtask

   task automatic test_wrap();
      bit seen;
      logic [31:0] e;
      count_in = 32'd2147483645; cfg_valid = 1'b1; cfg_delta = 31'd4; cfg_periodic = 1'b0;
      exp_q.push_back(32'd1);
      step();
      cfg_valid = 1'b0;
      wait_valid(20, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL wrap_timeout: got no alarm want alarm"); end
      else begin
         e = exp_q.pop_front();
         if (count_in !== 32'd2 || alarm_stamp !== e) begin
            errors++; $display("FAIL wrap_event: got count=%0d stamp=%0d want count=2 stamp=%0d", count_in, alarm_stamp, e);
         end
      end
      step();
   endtask

   task automatic test_periodic();
      int last_cyc, events;
      logic [31:0] e;
      count_in = 32'd10; cfg_valid = 1'b1; cfg_delta = 31'd3; cfg_periodic = 1'b1; alarm_ready = 1'b1;
      for (int k = 1; k <= 3; k++) exp_q.push_back(32'd10 + 32'(3 * k));
      step();
      cfg_valid = 1'b0;
      events = 0; last_cyc = 0;
      for (int i = 0; i < 30 && events < 3; i++) begin
         step();
         if (alarm_valid) begin
            e = exp_q.pop_front();
            checks++; if (alarm_stamp !== e || overrun !== 1'b0) begin
               errors++; $display("FAIL periodic_stamp: got stamp=%0d ovr=%b want stamp=%0d ovr=0", alarm_stamp, overrun, e);
            end
            if (events > 0) begin
               checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL periodic_spacing: got %0d want 3", cyc - last_cyc); end
            end
            last_cyc = cyc; events++;
         end
      end
      checks++; if (events != 3) begin errors++; $display("FAIL periodic_count: got %0d want 3", events); end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (busy !== 1'b0 || alarm_valid !== 1'b0) begin
         errors++; $display("FAIL periodic_cancel: got busy=%b valid=%b want 0 0", busy, alarm_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      count_in = 32'd400; cfg_valid = 1'b1; cfg_delta = 31'd1; cfg_periodic = 1'b1; alarm_ready = 1'b1;
      for (int k = 1; k <= 3; k++) exp_q.push_back(32'd400 + 32'(k));
      step();
      cfg_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         e = exp_q.pop_front();
         checks++; if (alarm_valid !== 1'b1 || alarm_stamp !== e) begin
            errors++; $display("FAIL b2b_stamp: got valid=%b stamp=%0d want 1 %0d", alarm_valid, alarm_stamp, e);
         end
      end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (alarm_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_cancel: got valid=%b busy=%b want 0 0", alarm_valid, busy);
      end
   endtask

   task automatic test_overrun();
      bit seen;
      logic [31:0] e;
      count_in = 32'd30; cfg_valid = 1'b1; cfg_delta = 31'd2; cfg_periodic = 1'b1; alarm_ready = 1'b0;
      exp_q.push_back(32'd32);
      step();
      cfg_valid = 1'b0;
      wait_valid(10, seen);
      e = exp_q.pop_front();
      checks++; if (!seen || alarm_stamp !== e || overrun !== 1'b0) begin
         errors++; $display("FAIL overrun_first: got seen=%b stamp=%0d ovr=%b want 1 %0d 0", seen, alarm_stamp, overrun, e);
      end
      step(); step();
      checks++; if (overrun !== 1'b1 || alarm_valid !== 1'b1 || alarm_stamp !== e) begin
         errors++; $display("FAIL overrun_set: got ovr=%b valid=%b stamp=%0d want 1 1 %0d", overrun, alarm_valid, alarm_stamp, e);
      end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (state_dbg !== IDLE || alarm_valid !== 1'b1) begin
         errors++; $display("FAIL overrun_cancel_keep: got state=%0d valid=%b want 0 1", state_dbg, alarm_valid);
      end
      alarm_ready = 1'b1;
      step();
      checks++; if (alarm_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_flush: got valid=%b ovr=%b want 0 1", alarm_valid, overrun);
      end
      cfg_valid = 1'b1; cfg_delta = 31'd50; cfg_periodic = 1'b0;
      step();
      cfg_valid = 1'b0;
      checks++; if (overrun !== 1'b0 || state_dbg !== ARMED) begin
         errors++; $display("FAIL overrun_clear: got ovr=%b state=%0d want 0 1", overrun, state_dbg);
      end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
   endtask

   task automatic test_cancel_match();
      count_in = 32'd200; cfg_valid = 1'b1; cfg_delta = 31'd3; cfg_periodic = 1'b0; alarm_ready = 1'b1;
      step();
      cfg_valid = 1'b0;
      step(); step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (alarm_valid !== 1'b0 || state_dbg !== IDLE) begin
         errors++; $display("FAIL cancel_match: got valid=%b state=%0d want 0 0", alarm_valid, state_dbg);
      end
      step();
      checks++; if (alarm_valid !== 1'b0) begin errors++; $display("FAIL cancel_late: got %b want 0", alarm_valid); end
   endtask

   task automatic test_reset_wait_ack();
      bit seen;
      logic [31:0] e;
      count_in = 32'd300; cfg_valid = 1'b1; cfg_delta = 31'd2; cfg_periodic = 1'b0; alarm_ready = 1'b0;
      exp_q.push_back(32'd302);
      step();
      cfg_valid = 1'b0;
      wait_valid(10, seen);
      e = exp_q.pop_front();
      checks++; if (!seen || alarm_stamp !== e || state_dbg !== WAIT_ACK) begin
         errors++; $display("FAIL waitack_enter: got seen=%b stamp=%0d state=%0d want 1 %0d 2", seen, alarm_stamp, state_dbg, e);
      end
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (state_dbg !== WAIT_ACK || alarm_valid !== 1'b1) begin
         errors++; $display("FAIL waitack_cancel: got state=%0d valid=%b want 2 1", state_dbg, alarm_valid);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (alarm_valid !== 1'b0 || busy !== 1'b0 || alarm_stamp !== 32'd0) begin
         errors++; $display("FAIL waitack_reset: got valid=%b busy=%b stamp=%0d want 0 0 0", alarm_valid, busy, alarm_stamp);
      end
      alarm_ready = 1'b1;
   endtask

   task automatic test_delta0();
      int n;
      bit seen;
      logic [31:0] e;
      count2 = 32'd7; cfg_valid2 = 1'b1; cfg_delta = 31'd0; cfg_periodic = 1'b0; alarm_ready = 1'b1;
      exp_q.push_back(32'd7);
      step();
      cfg_valid2 = 1'b0;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         n++;
         if (alarm_valid2) begin
            seen = 1'b1;
            break;
         end
      end
      e = exp_q.pop_front();
      checks++; if (!seen || n != 16 || alarm_stamp2 !== e) begin
         errors++; $display("FAIL delta0_fire: got seen=%b cycles=%0d stamp=%0d want 1 16 %0d", seen, n, alarm_stamp2, e);
      end
      step();
      checks++; if (busy2 !== 1'b0 || alarm_valid2 !== 1'b0) begin
         errors++; $display("FAIL delta0_idle: got busy=%b valid=%b want 0 0", busy2, alarm_valid2);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_wrap();
      test_periodic();
      test_back_to_back();
      test_overrun();
      test_cancel_match();
      test_reset_wait_ack();
      test_delta0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 Parameter CNT_MAX, default 2147483647, last value of the upstream free-running counter before it wraps to 0; the modulus is CNT_MAX+1.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 count_in  input  32  registered free-running count from the upstream counter, sequence 0..CNT_MAX, +1 per cycle.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  configuration may be accepted this cycle.
REQ-007 cfg_delta  input  31  alarm distance in counts; 0 means one full period (CNT_MAX+1).
REQ-008 cfg_periodic  input  1  1 = auto-rearm after each fire, 0 = one-shot.
REQ-009 cancel  input  1  abort the armed alarm.
REQ-010 alarm_valid  output  1  alarm event pending.
REQ-011 alarm_ready  input  1  consumer accepts the alarm event.
REQ-012 alarm_stamp  output  32  target count that fired, valid while alarm_valid=1.
REQ-013 overrun  output  1  sticky: a fire occurred while a previous event was still pending.
REQ-014 busy  output  1  1 when not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, ARMED and WAIT_ACK.
REQ-016 cfg_ready SHALL equal (state==IDLE) and SHALL NOT depend on cfg_valid.
REQ-017 A cfg_valid&cfg_ready cycle SHALL latch target=(count_in+delta_eff) mod (CNT_MAX+1), where delta_eff=cfg_delta, or CNT_MAX+1 when cfg_delta=0; it SHALL also latch the mode and clear overrun, and the next state SHALL be ARMED.
REQ-018 Target arithmetic SHALL use a 33-bit intermediate, so no overflow is possible before the modulo.
REQ-019 A fire SHALL occur in cycle N when state==ARMED and count_in==target; alarm_valid SHALL be 1 from cycle N+1 with alarm_stamp=target (latency 1).
REQ-020 Matching SHALL NOT start in the acceptance cycle; with delta 0 the fire therefore occurs CNT_MAX+1 cycles after acceptance.
REQ-021 One-shot fire: ARMED -> WAIT_ACK; WAIT_ACK -> IDLE in the cycle alarm_valid&alarm_ready.
REQ-022 Periodic fire: the FSM SHALL stay in ARMED and set target=(target+delta_eff) mod (CNT_MAX+1).
REQ-023 alarm_valid and alarm_stamp SHALL stay stable until accepted; alarm_valid SHALL clear on acceptance unless a new fire occurs in the same cycle, in which case it stays 1 with the new stamp.
REQ-024 A periodic fire while alarm_valid=1 and alarm_ready=0 SHALL set overrun and leave alarm_stamp unchanged; the dropped event is lost.
REQ-025 In ARMED, cancel SHALL force the next state to IDLE and suppress any same-cycle fire; an already pending alarm_valid SHALL be retained until accepted.
REQ-026 In WAIT_ACK, cancel SHALL have no effect; in IDLE, cancel SHALL be ignored.
REQ-027 Wrap-around: targets SHALL lie in 0..CNT_MAX; the transition CNT_MAX -> 0 of count_in needs no special handling.
REQ-028 If count_in skips the target value, no fire SHALL occur until count_in equals the target.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL enter IDLE with alarm_valid=0, alarm_stamp=0, overrun=0, busy=0 and target=0.
REQ-030 Reset SHALL take priority over every input, including mid-operation in ARMED or WAIT_ACK, and a pending alarm SHALL be discarded.
REQ-031 cfg_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset is released.

Structure
REQ-032 The package alarm_timer_pkg SHALL hold the state enum (IDLE, ARMED, WAIT_ACK), the CNT_MOD constant (CNT_MAX+1) and the count type (32-bit).
REQ-033 The modulo add SHALL be one combinational sub-module, mod_add_wrap, instantiated for both the initial target and the periodic rearm.

Verification
REQ-034 Bench: count_in=100 at acceptance, delta=5, one-shot, alarm_ready=1 -> alarm_valid high exactly in the cycle count_in=106, stamp=105, then IDLE and cfg_ready=1.
REQ-035 Bench: acceptance at count_in=2147483645, delta=4 -> target=1, fire when count_in=1, alarm_valid the next cycle with stamp=1.
REQ-036 Bench: periodic, delta=3, start at count_in 10, alarm_ready=1 -> stamps 13, 16, 19 on consecutive events, each 3 cycles apart, and overrun stays 0.
REQ-037 Bench: periodic, delta=2, alarm_ready=0 -> first stamp held; the second fire sets overrun=1 while the stamp is unchanged; a new cfg accepted after the flush clears overrun.
REQ-038 Bench: cancel asserted in the same cycle as the match -> no alarm_valid and state IDLE next cycle; reset asserted in WAIT_ACK -> alarm_valid=0 and busy=0 next cycle.
REQ-039 Bench: delta=0 with a reduced parameter CNT_MAX=15 -> fire after 16 cycles with stamp equal to count_in at acceptance.
